mem_stage_lsu: RTL

Load/store unit and MEM/WB pipeline register for the 5-stage pipeline. Takes the EX/MEM-registered instruction, drives the word-addressed data memory (byte address, word write, asynchronous read), performs byte/halfword extraction and read-merge-write for sub-word stores, and registers the writeback result for the WB stage. Owns stall/flush handling for the MEM→WB boundary and misalignment detection.

---
 rtl/mem_stage_lsu_if.sv | 39 +++
 rtl/mem_stage_lsu.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// EX/MEM instruction slot, data-memory bus and MEM/WB result bundle for mem_stage_lsu.
// The LSU takes the slave view; the pipeline/memory environment takes the master view.
interface mem_stage_lsu_if;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        flush;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic [31:0] misalign_addr;

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
    input  ex_size, ex_unsigned, ex_reg_write, ex_rd, stall, flush, dm_rd,
    output dm_addr, dm_we, dm_wd,
    output wb_valid, wb_reg_write, wb_rd, wb_data, misalign, misalign_addr
  );

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
    output ex_size, ex_unsigned, ex_reg_write, ex_rd, stall, flush, dm_rd,
    input  dm_addr, dm_we, dm_wd,
    input  wb_valid, wb_reg_write, wb_rd, wb_data, misalign, misalign_addr
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Load/store unit and MEM/WB pipeline register: sub-word load extraction, read-merge-write stores.
// Optional feature macro MEM_STAGE_MISALIGN_TRAP_EN enables misaligned-access trapping.
module mem_stage_lsu (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave lsu
);

  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [1:0]  size,
    input logic        uns
  );
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    logic [31:0]        r;
    b_s = word[{lane, 3'b000} +: 8];
    h_s = word[{lane[1], 4'b0000} +: 16];
    r   = word;
    case (size)
      2'b00: begin
        ext_s = b_s;
        if (uns) r = {24'd0, b_s};
        else     r = ext_s;
      end
      2'b01: begin
        ext_s = h_s;
        if (uns) r = {16'd0, h_s};
        else     r = ext_s;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  // Sub-word stores overwrite one lane of the current word; dm_rd is asynchronous so this fits in one cycle.
  function automatic logic [31:0] store_merge(
    input logic [31:0] word,
    input logic [31:0] data,
    input logic [1:0]  lane,
    input logic [1:0]  size
  );
    logic [31:0] r;
    r = word;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8]     = data[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: r = data;
    endcase
    return r;
  endfunction

  logic [31:0] addr;
  logic        live;
  logic        fault;
  logic        hold;
  logic [31:0] load_data;
  logic [31:0] result;

  logic        wb_valid_d,     wb_valid_q;
  logic        wb_reg_write_d, wb_reg_write_q;
  logic [4:0]  wb_rd_d,        wb_rd_q;
  logic [31:0] wb_data_d,      wb_data_q;

  assign addr = lsu.ex_alu_result;
  assign live = lsu.ex_valid & ~lsu.flush;
  assign hold = lsu.stall & ~lsu.flush;

  assign load_data = load_extract(lsu.dm_rd, addr[1:0], lsu.ex_size, lsu.ex_unsigned);
  assign result    = lsu.ex_mem_read ? load_data : addr;

  assign lsu.dm_addr = addr;
  assign lsu.dm_wd   = store_merge(lsu.dm_rd, lsu.ex_store_data, addr[1:0], lsu.ex_size);
  assign lsu.dm_we   = live & lsu.ex_mem_write & ~lsu.stall & ~fault;

  always_comb begin
    wb_valid_d     = live;
    wb_reg_write_d = live & lsu.ex_reg_write & ~fault;
    wb_rd_d        = lsu.ex_rd;
    wb_data_d      = result;
  end

  // MEM -> WB boundary; a flush while stalled still advances so the bubble lands in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= 32'd0;
    end else if (!hold) begin
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
    end
  end

  assign lsu.wb_valid     = wb_valid_q;
  assign lsu.wb_reg_write = wb_reg_write_q;
  assign lsu.wb_rd        = wb_rd_q;
  assign lsu.wb_data      = wb_data_q;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic        misaligned;
  logic        misalign_d,      misalign_q;
  logic [31:0] misalign_addr_d, misalign_addr_q;

  always_comb begin
    misaligned = 1'b0;
    case (lsu.ex_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      default: misaligned = |addr[1:0];
    endcase
  end

  assign fault = misaligned & (lsu.ex_mem_read | lsu.ex_mem_write);

  always_comb begin
    misalign_d      = live & fault;
    misalign_addr_d = misalign_addr_q;
    if (live & fault) misalign_addr_d = addr;
  end

  // Pulse is cleared while held so a stalled faulting access reports only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'd0;
    end else if (hold) begin
      misalign_q      <= 1'b0;
    end else begin
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign lsu.misalign      = misalign_q;
  assign lsu.misalign_addr = misalign_addr_q;
`else
  assign fault             = 1'b0;
  assign lsu.misalign      = 1'b0;
  assign lsu.misalign_addr = 32'd0;
`endif

endmodule
